axi_wr_data_sync_fifo: RTL and testbench



---
 rtl/axi_wr_data_sync_fifo.sv | 111 +++++++++++
 tb/tb_axi_wr_data_sync_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_data_sync_fifo.sv
// Single-clock FWFT FIFO for the AXI4 write-data channel (WDATA/WSTRB/WLAST).
// It reports its fill level and can optionally hold beats back until a whole burst is stored.
module axi_wr_data_sync_fifo #(
    parameter int DATA_WIDTH       = 32,
    parameter int STRB_WIDTH       = DATA_WIDTH / 8,
    parameter int DEPTH_WIDTH      = 6,
    parameter int ALMOST_FULL_NUM  = 60,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int PACKET_MODE      = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  s_wdata,
    input  logic [STRB_WIDTH-1:0]  s_wstrb,
    input  logic                   s_wlast,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic [STRB_WIDTH-1:0]  m_wstrb,
    output logic                   m_wlast,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   pkt_count,
    output logic                   pkt_err
);

    localparam int                 DEPTH     = 1 << DEPTH_WIDTH;
    localparam int                 EW        = DATA_WIDTH + STRB_WIDTH + 1;
    localparam logic [DEPTH_WIDTH:0] LVL_FULL = DEPTH[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] LVL_AF   = ALMOST_FULL_NUM[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] LVL_AE   = ALMOST_EMPTY_NUM[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] ONE      = {{DEPTH_WIDTH{1'b0}}, 1'b1};
    localparam bit                 PKT       = (PACKET_MODE != 0);

    logic [EW-1:0]        mem [DEPTH];
    logic [DEPTH_WIDTH:0] wr_ptr;
    logic [DEPTH_WIDTH:0] rd_ptr;
    logic                 ready_en;
    logic                 cut;
    logic                 wr_en;
    logic                 rd_en;
    logic                 wr_last;
    logic                 rd_last;

    assign full         = (level == LVL_FULL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= LVL_AF);
    assign almost_empty = (level <= LVL_AE);

    assign s_wready = ready_en & ~full;
    assign {m_wlast, m_wstrb, m_wdata} = mem[rd_ptr[DEPTH_WIDTH-1:0]];
    // In packet mode the head waits for a complete burst unless cut-through is active.
    assign m_wvalid = ~empty & (~PKT | (pkt_count != '0) | cut);

    assign wr_en   = s_wvalid & s_wready;
    assign rd_en   = m_wvalid & m_wready;
    assign wr_last = wr_en & s_wlast;
    assign rd_last = rd_en & m_wlast;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr[DEPTH_WIDTH-1:0]] <= {s_wlast, s_wstrb, s_wdata};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
            ready_en  <= 1'b0;
            cut       <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                pkt_count <= '0;
                cut       <= 1'b0;
                pkt_err   <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + ONE;
                if (rd_en) rd_ptr <= rd_ptr + ONE;

                if (wr_en && !rd_en)      level <= level + ONE;
                else if (rd_en && !wr_en) level <= level - ONE;

                if (wr_last && !rd_last)      pkt_count <= pkt_count + ONE;
                else if (rd_last && !wr_last) pkt_count <= pkt_count - ONE;

                // A full FIFO with no burst end can never drain in packet mode; release it.
                if (PKT && full && (pkt_count == '0)) begin
                    cut     <= 1'b1;
                    pkt_err <= 1'b1;
                end else if (rd_last) begin
                    cut <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_data_sync_fifo.sv
// Directed bench for axi_wr_data_sync_fifo: one cut-through and one packet-mode instance,
// with hand-computed expectations for fill, drain, streaming, packet gating, flush and reset.
module tb_axi_wr_data_sync_fifo;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        flush, s_wlast, s_wvalid, m_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wready, m_wlast, m_wvalid, full, empty, almost_full, almost_empty, pkt_err;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [6:0]  level, pkt_count;

    logic        p_flush, p_s_wlast, p_s_wvalid, p_m_wready;
    logic [31:0] p_s_wdata;
    logic [3:0]  p_s_wstrb;
    logic        p_s_wready, p_m_wlast, p_m_wvalid, p_full, p_empty, p_almost_full, p_almost_empty, p_pkt_err;
    logic [31:0] p_m_wdata;
    logic [3:0]  p_m_wstrb;
    logic [6:0]  p_level, p_pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_wr_data_sync_fifo #(.PACKET_MODE(0)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .level(level), .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .pkt_count(pkt_count), .pkt_err(pkt_err)
    );

    axi_wr_data_sync_fifo #(.PACKET_MODE(1)) dut1 (
        .clk(clk), .rstn(rstn), .flush(p_flush),
        .s_wdata(p_s_wdata), .s_wstrb(p_s_wstrb), .s_wlast(p_s_wlast), .s_wvalid(p_s_wvalid), .s_wready(p_s_wready),
        .m_wdata(p_m_wdata), .m_wstrb(p_m_wstrb), .m_wlast(p_m_wlast), .m_wvalid(p_m_wvalid), .m_wready(p_m_wready),
        .level(p_level), .full(p_full), .empty(p_empty), .almost_full(p_almost_full), .almost_empty(p_almost_empty),
        .pkt_count(p_pkt_count), .pkt_err(p_pkt_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int wr;
        flush = 0; s_wlast = 0; s_wvalid = 0; m_wready = 0; s_wdata = '0; s_wstrb = '0;
        p_flush = 0; p_s_wlast = 0; p_s_wvalid = 0; p_m_wready = 0; p_s_wdata = '0; p_s_wstrb = '0;
        #12;
        chk("rst_level",   64'(level), 64'd0);
        chk("rst_empty",   64'(empty), 64'd1);
        chk("rst_full",    64'(full), 64'd0);
        chk("rst_ae",      64'(almost_empty), 64'd1);
        chk("rst_af",      64'(almost_full), 64'd0);
        chk("rst_mvalid",  64'(m_wvalid), 64'd0);
        chk("rst_wready",  64'(s_wready), 64'd0);
        chk("rst_pkterr",  64'(pkt_err), 64'd0);
        chk("rst_pkt",     64'(pkt_count), 64'd0);
        chk("rst_p_mvalid", 64'(p_m_wvalid), 64'd0);
        @(negedge clk);
        rstn = 1;
        tick;
        chk("rel_wready", 64'(s_wready), 64'd1);

        // fill 64 beats with no reads
        for (int i = 0; i < 64; i++) begin
            s_wdata = 32'(i); s_wstrb = 4'hF; s_wlast = (i == 63); s_wvalid = 1;
            chk("t1_wready", 64'(s_wready), 64'd1);
            tick;
            chk("t1_level", 64'(level), 64'(i + 1));
            chk("t1_af", 64'(almost_full), 64'((i + 1) >= 60));
        end
        s_wdata = 32'hDEAD; s_wlast = 0;
        repeat (3) begin
            tick;
            chk("t1_held_level", 64'(level), 64'd64);
            chk("t1_held_wready", 64'(s_wready), 64'd0);
        end
        s_wvalid = 0;
        chk("t1_full", 64'(full), 64'd1);
        chk("t1_pkt", 64'(pkt_count), 64'd1);
        chk("t1_pkterr", 64'(pkt_err), 64'd0);

        // drain in order
        m_wready = 1;
        for (int i = 0; i < 64; i++) begin
            chk("t2_mvalid", 64'(m_wvalid), 64'd1);
            chk("t2_data", 64'(m_wdata), 64'(i));
            chk("t2_strb", 64'(m_wstrb), 64'hF);
            chk("t2_last", 64'(m_wlast), 64'(i == 63));
            tick;
            chk("t2_level", 64'(level), 64'(63 - i));
            chk("t2_ae", 64'(almost_empty), 64'((63 - i) <= 4));
        end
        chk("t2_empty", 64'(empty), 64'd1);
        chk("t2_mvalid_end", 64'(m_wvalid), 64'd0);
        chk("t2_pkt", 64'(pkt_count), 64'd0);
        m_wready = 0;

        // streaming at constant level 10 across pointer wrap
        s_wlast = 0;
        for (int i = 0; i < 10; i++) begin
            s_wdata = 32'(1000 + i); s_wvalid = 1;
            tick;
        end
        chk("t3_level_pre", 64'(level), 64'd10);
        rd = 1000; wr = 1010;
        m_wready = 1;
        repeat (200) begin
            s_wdata = 32'(wr);
            chk("t3_data", 64'(m_wdata), 64'(rd));
            tick;
            rd++; wr++;
            chk("t3_level", 64'(level), 64'd10);
        end
        s_wvalid = 0;
        repeat (10) begin
            chk("t3_tail", 64'(m_wdata), 64'(rd));
            tick;
            rd++;
        end
        chk("t3_empty", 64'(empty), 64'd1);
        m_wready = 0;

        // packet mode: held until burst end
        p_s_wstrb = 4'h3;
        for (int i = 0; i < 4; i++) begin
            p_s_wdata = 32'(i); p_s_wlast = 0; p_s_wvalid = 1;
            tick;
            chk("t4_mvalid_hold", 64'(p_m_wvalid), 64'd0);
        end
        p_s_wvalid = 0; p_m_wready = 1;
        repeat (2) tick;
        chk("t4_level_hold", 64'(p_level), 64'd4);
        chk("t4_mvalid_idle", 64'(p_m_wvalid), 64'd0);
        p_m_wready = 0;
        p_s_wdata = 32'd4; p_s_wlast = 1; p_s_wvalid = 1;
        tick;
        p_s_wvalid = 0; p_s_wlast = 0;
        chk("t4_mvalid_go", 64'(p_m_wvalid), 64'd1);
        chk("t4_pkt1", 64'(p_pkt_count), 64'd1);
        p_m_wready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_data", 64'(p_m_wdata), 64'(i));
            chk("t4_last", 64'(p_m_wlast), 64'(i == 4));
            tick;
        end
        p_m_wready = 0;
        chk("t4_pkt0", 64'(p_pkt_count), 64'd0);
        chk("t4_empty", 64'(p_empty), 64'd1);
        chk("t4_pkterr", 64'(p_pkt_err), 64'd0);

        // packet mode: deadlock escape
        for (int i = 0; i < 64; i++) begin
            p_s_wdata = 32'(100 + i); p_s_wlast = 0; p_s_wvalid = 1;
            tick;
        end
        p_s_wvalid = 0;
        chk("t5_full", 64'(p_full), 64'd1);
        chk("t5_pkt", 64'(p_pkt_count), 64'd0);
        chk("t5_mvalid_pre", 64'(p_m_wvalid), 64'd0);
        chk("t5_pkterr_pre", 64'(p_pkt_err), 64'd0);
        tick;
        chk("t5_pkterr", 64'(p_pkt_err), 64'd1);
        chk("t5_mvalid_cut", 64'(p_m_wvalid), 64'd1);
        p_m_wready = 1;
        for (int i = 0; i < 64; i++) begin
            chk("t5_mvalid", 64'(p_m_wvalid), 64'd1);
            chk("t5_data", 64'(p_m_wdata), 64'(100 + i));
            tick;
        end
        p_m_wready = 0;
        chk("t5_empty", 64'(p_empty), 64'd1);
        chk("t5_mvalid_empty", 64'(p_m_wvalid), 64'd0);
        p_s_wdata = 32'h55; p_s_wlast = 1; p_s_wvalid = 1;
        tick;
        p_s_wvalid = 0; p_s_wlast = 0;
        chk("t5_last_valid", 64'(p_m_wvalid), 64'd1);
        p_m_wready = 1;
        chk("t5_last_data", 64'(p_m_wdata), 64'h55);
        chk("t5_last_flag", 64'(p_m_wlast), 64'd1);
        tick;
        p_m_wready = 0;
        chk("t5_pkt_after", 64'(p_pkt_count), 64'd0);
        for (int i = 0; i < 2; i++) begin
            p_s_wdata = 32'(200 + i); p_s_wvalid = 1;
            tick;
        end
        p_s_wvalid = 0;
        chk("t5_saf_resumed", 64'(p_m_wvalid), 64'd0);
        chk("t5_level2", 64'(p_level), 64'd2);
        chk("t5_pkterr_sticky", 64'(p_pkt_err), 64'd1);
        p_flush = 1;
        tick;
        p_flush = 0;
        chk("t5_flush_pkterr", 64'(p_pkt_err), 64'd0);
        chk("t5_flush_level", 64'(p_level), 64'd0);

        // flush with a simultaneous write
        for (int i = 0; i < 20; i++) begin
            s_wdata = 32'(500 + i); s_wvalid = 1;
            tick;
        end
        chk("t6_level20", 64'(level), 64'd20);
        s_wdata = 32'd777; flush = 1;
        tick;
        flush = 0; s_wvalid = 0;
        chk("t6_level0", 64'(level), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_mvalid", 64'(m_wvalid), 64'd0);
        chk("t6_pkterr", 64'(pkt_err), 64'd0);
        chk("t6_wready", 64'(s_wready), 64'd1);
        s_wdata = 32'd42; s_wvalid = 1;
        tick;
        chk("t6_head", 64'(m_wdata), 64'd42);
        chk("t6_level1", 64'(level), 64'd1);
        s_wdata = 32'd7;
        tick;
        s_wdata = 32'd8;
        #2;
        rstn = 0;
        #1;
        chk("t6_rst_level", 64'(level), 64'd0);
        chk("t6_rst_empty", 64'(empty), 64'd1);
        chk("t6_rst_full", 64'(full), 64'd0);
        chk("t6_rst_ae", 64'(almost_empty), 64'd1);
        chk("t6_rst_wready", 64'(s_wready), 64'd0);
        chk("t6_rst_mvalid", 64'(m_wvalid), 64'd0);
        chk("t6_rst_pkt", 64'(pkt_count), 64'd0);
        s_wvalid = 0;
        @(negedge clk);
        rstn = 1;
        repeat (3) tick;
        chk("t6_post_mvalid", 64'(m_wvalid), 64'd0);
        chk("t6_post_level", 64'(level), 64'd0);
        chk("t6_post_wready", 64'(s_wready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
